// File: rtl/zicntr_hpm_bank.sv
// RISC-V counter/CSR bank: mcycle, minstret, NUM_HPM mhpmcounters, mcountinhibit, event selectors, user aliases.
// Optional feature macro HPM_OVERFLOW_IRQ_EN: sticky per-hpm overflow flags at CSR 7C0 driving ovf_irq.
module zicntr_hpm_bank #(
    parameter int NUM_HPM    = 4,
    parameter int CNT_WIDTH  = 64,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [11:0]           csr_addr,
    input  logic [31:0]           csr_wdata,
    input  logic                  csr_we,
    output logic [31:0]           csr_rdata,
    output logic                  csr_hit,
    input  logic                  instret_inc,
    input  logic [NUM_EVENTS-1:0] hpm_events,
    output logic                  ovf_irq
);
    localparam int NC = 3 + NUM_HPM;
    localparam int NH = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam int EW = $clog2(NUM_EVENTS + 1);
    localparam int HW = CNT_WIDTH - 32;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    function automatic logic [31:0] impl_mask();
        logic [31:0] m;
        m = 32'h5;
        for (int i = 0; i < NUM_HPM; i++) m[3+i] = 1'b1;
        return m;
    endfunction
    localparam logic [31:0] INH_MASK = impl_mask();

    // Index 1 is the time slot: never written or enabled, so it stays 0.
    cnt_t          cnt [NC];
    logic [EW-1:0] sel [NH];
    logic [31:0]   inh;
    logic [NC-1:0] en, wr_lo, wr_hi;

    always_comb begin
        en    = '0;
        wr_lo = '0;
        wr_hi = '0;
        for (int n = 0; n < NC; n++) begin
            if (n != 1) begin
                wr_lo[n] = csr_we && (csr_addr == 12'hB00 + 12'(n));
                wr_hi[n] = csr_we && (csr_addr == 12'hB80 + 12'(n));
            end
        end
        en[0] = !inh[0];
        en[2] = instret_inc && !inh[2];
        for (int i = 0; i < NUM_HPM; i++)
            for (int k = 0; k < NUM_EVENTS; k++)
                if (sel[i] == EW'(k + 1) && hpm_events[k] && !inh[3+i]) en[3+i] = 1'b1;
    end

    for (genvar n = 0; n < NC; n++) begin : g_cnt
        always_ff @(posedge clk or posedge reset) begin
            if (reset)           cnt[n] <= '0;
            else if (wr_lo[n])   cnt[n][31:0] <= csr_wdata;
            else if (wr_hi[n])   cnt[n][CNT_WIDTH-1:32] <= csr_wdata[HW-1:0];
            else if (en[n])      cnt[n] <= cnt[n] + cnt_t'(1);
        end
    end

    for (genvar i = 0; i < NH; i++) begin : g_sel
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                sel[i] <= '0;
            else if (i < NUM_HPM && csr_we && csr_addr == 12'h323 + 12'(i))
                sel[i] <= (csr_wdata > 32'(NUM_EVENTS)) ? '0 : csr_wdata[EW-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              inh <= '0;
        else if (csr_we && csr_addr == 12'h320) inh <= csr_wdata & INH_MASK;
    end

`ifdef HPM_OVERFLOW_IRQ_EN
    logic [31:0] ovf, ovf_set;

    // Only an increment can raise a flag; a written all-zero value never does.
    always_comb begin
        ovf_set = '0;
        for (int n = 3; n < NC; n++)
            ovf_set[n] = en[n] && !wr_lo[n] && !wr_hi[n] && (&cnt[n]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf     <= '0;
            ovf_irq <= 1'b0;
        end else begin
            ovf     <= (ovf & ~((csr_we && csr_addr == 12'h7C0) ? csr_wdata : 32'h0)) | ovf_set;
            ovf_irq <= |ovf;
        end
    end
`else
    assign ovf_irq = 1'b0;
`endif

    always_comb begin
        csr_rdata = '0;
        csr_hit   = 1'b0;
        for (int n = 0; n < NC; n++) begin
            if (n != 1) begin
                if (csr_addr == 12'hB00 + 12'(n) || csr_addr == 12'hC00 + 12'(n)) begin
                    csr_hit   = 1'b1;
                    csr_rdata = cnt[n][31:0];
                end
                if (csr_addr == 12'hB80 + 12'(n) || csr_addr == 12'hC80 + 12'(n)) begin
                    csr_hit   = 1'b1;
                    csr_rdata = 32'(cnt[n] >> 32);
                end
            end
        end
        if (csr_addr == 12'hC01) begin
            csr_hit   = 1'b1;
            csr_rdata = cnt[0][31:0];
        end
        if (csr_addr == 12'hC81) begin
            csr_hit   = 1'b1;
            csr_rdata = 32'(cnt[0] >> 32);
        end
        if (csr_addr == 12'h320) begin
            csr_hit   = 1'b1;
            csr_rdata = inh;
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            if (csr_addr == 12'h323 + 12'(i)) begin
                csr_hit   = 1'b1;
                csr_rdata = 32'(sel[i]);
            end
        end
`ifdef HPM_OVERFLOW_IRQ_EN
        if (csr_addr == 12'h7C0) begin
            csr_hit   = 1'b1;
            csr_rdata = ovf;
        end
`endif
    end
endmodule

// File: tb/tb_zicntr_hpm_bank.sv
// Randomized bench for zicntr_hpm_bank against a per-counter arithmetic model, plus directed scenarios.
module tb_zicntr_hpm_bank;
    localparam int NH = 4;
    localparam int CW = 64;
    localparam int NE = 8;
    localparam logic [63:0] CMASK = (CW == 64) ? {64{1'b1}} : ((64'd1 << CW) - 64'd1);
    localparam logic [31:0] IMASK = 32'h5 | (((32'd1 << NH) - 32'd1) << 3);

    logic          clk, reset;
    logic [11:0]   csr_addr;
    logic [31:0]   csr_wdata, csr_rdata;
    logic          csr_we, csr_hit, instret_inc, ovf_irq;
    logic [NE-1:0] hpm_events;

    zicntr_hpm_bank #(.NUM_HPM(NH), .CNT_WIDTH(CW), .NUM_EVENTS(NE)) dut (
        .clk(clk), .reset(reset), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_we(csr_we), .csr_rdata(csr_rdata), .csr_hit(csr_hit),
        .instret_inc(instret_inc), .hpm_events(hpm_events), .ovf_irq(ovf_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Model: counter n (0=cycle, 2=instret, 3+i=hpm) as a plain number.
    logic [63:0] m_cnt [3+NH];
    int          m_sel [NH];
    logic [31:0] m_inh, m_ovf;
    logic        m_irq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit valid_cnt(int n);
        return n == 0 || n == 2 || (n >= 3 && n < 3 + NH);
    endfunction

    task automatic m_reset();
        for (int n = 0; n < 3 + NH; n++) m_cnt[n] = 64'h0;
        for (int i = 0; i < NH; i++) m_sel[i] = 0;
        m_inh = 0; m_ovf = 0; m_irq = 0;
    endtask

    task automatic m_read(input logic [11:0] a, output logic h, output logic [31:0] d);
        int n;
        h = 0; d = 0;
        if (a >= 12'hB00 && a < 12'hB20) begin
            n = int'(a - 12'hB00);
            if (valid_cnt(n)) begin h = 1; d = m_cnt[n][31:0]; end
        end else if (a >= 12'hB80 && a < 12'hBA0) begin
            n = int'(a - 12'hB80);
            if (valid_cnt(n)) begin h = 1; d = m_cnt[n][63:32]; end
        end else if (a >= 12'hC00 && a < 12'hC20) begin
            n = int'(a - 12'hC00);
            if (n == 1) n = 0;
            if (valid_cnt(n)) begin h = 1; d = m_cnt[n][31:0]; end
        end else if (a >= 12'hC80 && a < 12'hCA0) begin
            n = int'(a - 12'hC80);
            if (n == 1) n = 0;
            if (valid_cnt(n)) begin h = 1; d = m_cnt[n][63:32]; end
        end else if (a == 12'h320) begin
            h = 1; d = m_inh;
        end else if (a >= 12'h323 && a < 12'h323 + NH) begin
            h = 1; d = m_sel[int'(a - 12'h323)];
        end
`ifdef HPM_OVERFLOW_IRQ_EN
        else if (a == 12'h7C0) begin
            h = 1; d = m_ovf;
        end
`endif
    endtask

    task automatic m_update(input logic [11:0] a, input logic we, input logic [31:0] wd,
                            input logic inst, input logic [NE-1:0] ev);
        logic [31:0] old_inh, set;
        logic        en;
        old_inh = m_inh;
        set     = 0;
        m_irq   = |m_ovf;
        for (int n = 0; n < 3 + NH; n++) begin
            if (!valid_cnt(n)) continue;
            if (n == 0)      en = !old_inh[0];
            else if (n == 2) en = inst && !old_inh[2];
            else en = m_sel[n-3] >= 1 && m_sel[n-3] <= NE && ev[m_sel[n-3]-1] && !old_inh[n];
            if (we && a == 12'hB00 + 12'(n))
                m_cnt[n] = {m_cnt[n][63:32], wd};
            else if (we && a == 12'hB80 + 12'(n))
                m_cnt[n] = {wd, m_cnt[n][31:0]} & CMASK;
            else if (en) begin
                m_cnt[n] = (m_cnt[n] + 64'd1) & CMASK;
                if (n >= 3 && m_cnt[n] == 0) set[n] = 1'b1;
            end
        end
        if (we && a == 12'h320) m_inh = wd & IMASK;
        for (int i = 0; i < NH; i++)
            if (we && a == 12'h323 + 12'(i)) m_sel[i] = (wd > NE) ? 0 : int'(wd);
`ifdef HPM_OVERFLOW_IRQ_EN
        m_ovf = (m_ovf & ~((we && a == 12'h7C0) ? wd : 32'h0)) | set;
`endif
    endtask

    // Apply inputs, check combinational outputs against the model, then clock once.
    task automatic step(input logic [11:0] a, input logic we, input logic [31:0] wd,
                        input logic inst, input logic [NE-1:0] ev);
        logic        h;
        logic [31:0] d;
        csr_addr = a; csr_we = we; csr_wdata = wd; instret_inc = inst; hpm_events = ev;
        #1;
        m_read(a, h, d);
        chk("rdata", csr_rdata, d);
        chk("hit", 32'(csr_hit), 32'(h));
        chk("irq", 32'(ovf_irq), 32'(m_irq));
        m_update(a, we, wd, inst, ev);
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [11:0] a);
        csr_addr = a; csr_we = 0; instret_inc = 0; hpm_events = '0;
        #1;
    endtask

    initial begin
        logic [11:0] a;
        logic [31:0] wd;
        csr_addr = 0; csr_we = 0; csr_wdata = 0; instret_inc = 0; hpm_events = '0;
        reset = 1'b1;
        m_reset();
        #12;
        peek(12'hB00); chk("rst_b00", csr_rdata, 0);
        chk("rst_irq", 32'(ovf_irq), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int c = 0; c < 10; c++) step(12'hC00, 0, 0, 0, '0);
        peek(12'hC00); chk("c00_10", csr_rdata, 10);
        peek(12'hC01); chk("c01_10", csr_rdata, 10);
        peek(12'hB02); chk("b02_0", csr_rdata, 0);

        step(12'hB00, 1, 32'hFFFF_FFFF, 0, '0);
        step(12'hB80, 1, 32'h1, 0, '0);
        step(12'hB00, 0, 0, 0, '0);
        peek(12'hB00); chk("carry_lo", csr_rdata, 0);
        peek(12'hB80); chk("carry_hi", csr_rdata, 2);
        step(12'hB00, 1, 32'h55, 0, '0);
        peek(12'hB00); chk("wr_beats_inc", csr_rdata, 32'h55);

        step(12'h323, 1, 2, 0, '0);
        for (int c = 0; c < 5; c++) step(12'hB03, 0, 0, 0, 8'h02);
        peek(12'hB03); chk("hpm3_5", csr_rdata, 5);
        step(12'h320, 1, 32'h8, 0, '0);
        for (int c = 0; c < 5; c++) step(12'hB03, 0, 0, 0, 8'h02);
        peek(12'hB03); chk("hpm3_inh", csr_rdata, 5);
        step(12'h323, 1, NE + 1, 0, '0);
        peek(12'h323); chk("sel_warl", csr_rdata, 0);

        step(12'h320, 1, 32'hFFFF_FFFF, 0, '0);
        peek(12'h320); chk("inh_warl", csr_rdata, 32'h7D);
        for (int c = 0; c < 5; c++) step(12'hB02, 0, 0, 1, '0);
        peek(12'hB02); chk("instret_frozen", csr_rdata, 0);

        step(12'hC00, 1, 32'h1234, 0, '0);
        peek(12'hC00); chk("c00_hit", 32'(csr_hit), 1);
        chk("c00_ignored", csr_rdata, m_cnt[0][31:0]);
        peek(12'h7FF); chk("unmap_hit", 32'(csr_hit), 0);
        chk("unmap_rdata", csr_rdata, 0);

        step(12'h320, 1, 0, 0, '0);
        step(12'h323, 1, 1, 0, '0);
        step(12'hB03, 1, 32'hFFFF_FFFF, 0, '0);
        step(12'hB83, 1, 32'hFFFF_FFFF, 0, '0);
        step(12'hB03, 0, 0, 0, 8'h01);
        peek(12'hB03); chk("wrap_lo", csr_rdata, 0);
        peek(12'hB83); chk("wrap_hi", csr_rdata, 0);
        step(12'hB03, 0, 0, 0, '0);
`ifdef HPM_OVERFLOW_IRQ_EN
        chk("irq_rise", 32'(ovf_irq), 1);
        peek(12'h7C0); chk("ovf_flag", csr_rdata, 32'h8);
        step(12'h7C0, 1, 32'h8, 0, '0);
        step(12'h7C0, 0, 0, 0, '0);
        chk("irq_clear", 32'(ovf_irq), 0);
`else
        chk("irq_tied", 32'(ovf_irq), 0);
        peek(12'h7C0); chk("7c0_unmap", 32'(csr_hit), 0);
`endif

        for (int c = 0; c < 800; c++) begin
            case ($urandom_range(0, 7))
                0: a = 12'hB00; 1: a = 12'hB80; 2: a = 12'hC00; 3: a = 12'hC80;
                4: a = 12'h320; 5: a = 12'h323; 6: a = 12'h7C0; default: a = 12'h300;
            endcase
            a = a + 12'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: wd = 32'hFFFF_FFFF;
                1: wd = $urandom_range(0, 10);
                2: wd = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: wd = $urandom;
            endcase
            if (a == 12'h320) wd = wd & 32'h0000_0AA8 & $urandom;
            step(a, ($urandom_range(0, 2) == 0), wd, 1'($urandom), NE'($urandom));
        end

        reset = 1'b1;
        m_reset();
        peek(12'hB00); chk("mid_rst_b00", csr_rdata, 0);
        peek(12'hC81); chk("mid_rst_c81", csr_rdata, 0);
        peek(12'h323); chk("mid_rst_sel", csr_rdata, 0);
        chk("mid_rst_irq", 32'(ovf_irq), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) step(12'hB00, 0, 0, 1, '1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
